// File: rtl/im_loader_pkg.sv
// Shared types and constants for the UART instruction-memory loader.
package im_loader_pkg;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

    localparam int DATA_BITS      = 8;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/im_loader_uart_rx.sv
// 8N1 UART receiver: rx synchronizer, down-counting baud timer and receive FSM.
// byte_valid_o / frame_err_o pulse in the cycle the stop bit is sampled.
//
// state    | meaning
// RX_IDLE  | waiting for a falling edge on the synchronized line
// RX_START | half-bit wait, confirm start bit is still low
// RX_DATA  | sample 8 data bits, one per bit period, LSB first
// RX_STOP  | sample stop bit, flag byte or framing error
module uart_rx
    import im_loader_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx_i,
    output logic [7:0] byte_o,
    output logic       byte_valid_o,
    output logic       frame_err_o
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1  = CNT_W'(DIV - 1);

    logic             r_rx_meta;
    logic             r_rx_sync;
    logic             r_rx_last;
    rx_state_t        r_state;
    rx_state_t        w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [2:0]       r_bit_idx;
    logic [2:0]       w_bit_idx_next;
    logic [7:0]       r_shift;
    logic [7:0]       w_shift_next;
    logic             w_rx;
    logic             w_tc;

    assign w_rx   = r_rx_sync;
    assign w_tc   = (r_cnt == '0);
    assign byte_o = r_shift;

    // Synchronizer and edge history reset to the idle-high line level.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_rx_last <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_sync <= r_rx_meta;
            r_rx_last <= r_rx_sync;
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_bit_idx <= w_bit_idx_next;
            r_shift   <= w_shift_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_bit_idx_next = r_bit_idx;
        w_shift_next   = r_shift;
        byte_valid_o   = 1'b0;
        frame_err_o    = 1'b0;
        case (r_state)
            RX_IDLE: begin
                if (r_rx_last && !w_rx) begin
                    w_state_next = RX_START;
                    w_cnt_next   = HALF_M1;
                end
            end
            RX_START: begin
                if (!w_tc) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else if (!w_rx) begin
                    w_state_next   = RX_DATA;
                    w_cnt_next     = BIT_M1;
                    w_bit_idx_next = '0;
                end else begin
                    w_state_next = RX_IDLE;
                end
            end
            RX_DATA: begin
                if (!w_tc) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_shift_next = {w_rx, r_shift[7:1]};
                    w_cnt_next   = BIT_M1;
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_state_next = RX_STOP;
                    end else begin
                        w_bit_idx_next = r_bit_idx + 1'b1;
                    end
                end
            end
            RX_STOP: begin
                if (!w_tc) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    // Returning to idle at mid-stop leaves half a bit to catch a back-to-back start edge.
                    byte_valid_o = w_rx;
                    frame_err_o  = !w_rx;
                    w_state_next = RX_IDLE;
                end
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

endmodule

// File: rtl/im_loader.sv
// UART boot loader: assembles little-endian words from received bytes and writes them to instruction memory.
// Optional running checksum of written words enabled by the macro IM_LOADER_CHECKSUM_EN.
module im_loader
    import im_loader_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              rx_i,
    input  logic              load_en_i,
    output logic              cpu_hold_o,
    output logic              im_we_o,
    output logic [ADDR_W-1:0] im_addr_o,
    output logic [31:0]       im_wdata_o,
    output logic [15:0]       word_cnt_o,
    output logic              frame_err_o,
    output logic [31:0]       checksum_o
);

    logic [7:0]        w_byte;
    logic              w_byte_valid;
    logic              w_frame_err;
    logic              r_len_meta;
    logic              r_len_sync;
    logic              r_len_last;
    logic              w_len_rise;
    logic              w_len_fall;
    logic [1:0]        r_byte_cnt;
    logic [23:0]       r_word;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [15:0]       r_word_cnt;
    logic              r_frame_err;

    uart_rx #(
        .CLK_HZ (CLK_HZ),
        .BAUD   (BAUD)
    ) u_uart_rx (
        .clk          (clk),
        .rstn         (rstn),
        .rx_i         (rx_i),
        .byte_o       (w_byte),
        .byte_valid_o (w_byte_valid),
        .frame_err_o  (w_frame_err)
    );

    assign w_len_rise  = r_len_sync && !r_len_last;
    assign w_len_fall  = !r_len_sync && r_len_last;
    assign cpu_hold_o  = r_len_sync;
    assign im_we_o     = r_we;
    assign im_addr_o   = r_addr;
    assign im_wdata_o  = r_wdata;
    assign word_cnt_o  = r_word_cnt;
    assign frame_err_o = r_frame_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_len_meta  <= 1'b0;
            r_len_sync  <= 1'b0;
            r_len_last  <= 1'b0;
            r_byte_cnt  <= '0;
            r_word      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_word_cnt  <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_len_meta <= load_en_i;
            r_len_sync <= r_len_meta;
            r_len_last <= r_len_sync;
            r_we       <= 1'b0;
            if (r_we) begin
                r_addr <= r_addr + 1'b1;
                if (r_word_cnt != 16'hFFFF) begin
                    r_word_cnt <= r_word_cnt + 1'b1;
                end
            end
            if (w_frame_err) begin
                r_frame_err <= 1'b1;
            end
            // Bytes count only while load mode is held; a completing byte on the falling edge is dropped.
            if (w_len_fall) begin
                r_byte_cnt <= '0;
            end else if (w_byte_valid && r_len_sync) begin
                r_byte_cnt <= r_byte_cnt + 1'b1;
                case (r_byte_cnt)
                    2'd0: r_word[7:0]   <= w_byte;
                    2'd1: r_word[15:8]  <= w_byte;
                    2'd2: r_word[23:16] <= w_byte;
                    default: begin
                        r_we    <= 1'b1;
                        r_wdata <= {w_byte, r_word};
                    end
                endcase
            end
            if (w_len_rise) begin
                r_addr      <= '0;
                r_byte_cnt  <= '0;
                r_word_cnt  <= '0;
                r_frame_err <= 1'b0;
                r_we        <= 1'b0;
            end
        end
    end

`ifdef IM_LOADER_CHECKSUM_EN
    logic [31:0] r_checksum;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_checksum <= '0;
        end else if (w_len_rise) begin
            r_checksum <= '0;
        end else if (r_we) begin
            r_checksum <= r_checksum + r_wdata;
        end
    end

    assign checksum_o = r_checksum;
`else
    assign checksum_o = '0;
`endif

endmodule

// File: tb/tb_im_loader.sv
// Self-checking bench for im_loader: byte-level loader model with a per-write scoreboard.
// Expected checksum follows IM_LOADER_CHECKSUM_EN.
module tb_im_loader;

    logic        clk;
    logic        rstn;
    logic        rx_i;
    logic        load_en_i;
    logic        cpu_hold_o;
    logic        im_we_o;
    logic [3:0]  im_addr_o;
    logic [31:0] im_wdata_o;
    logic [15:0] word_cnt_o;
    logic        frame_err_o;
    logic [31:0] checksum_o;

    im_loader #(
        .CLK_HZ (1000000),
        .BAUD   (100000),
        .ADDR_W (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rx_i        (rx_i),
        .load_en_i   (load_en_i),
        .cpu_hold_o  (cpu_hold_o),
        .im_we_o     (im_we_o),
        .im_addr_o   (im_addr_o),
        .im_wdata_o  (im_wdata_o),
        .word_cnt_o  (word_cnt_o),
        .frame_err_o (frame_err_o),
        .checksum_o  (checksum_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] data;
        logic [15:0] cnt;
    } wr_t;

    wr_t         exp_q[$];
    logic [7:0]  m_part[$];
    int          m_addr;
    int          m_cnt;
    logic [31:0] m_sum;
    bit          m_len;
    bit          m_ferr;

    int          n_checks;
    int          n_pass;
    int          n_writes;
    logic [3:0]  last_addr;
    logic [31:0] last_data;
    bit          prev_we;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic model_clear();
        m_addr = 0;
        m_cnt  = 0;
        m_sum  = '0;
        m_ferr = 0;
        m_part.delete();
    endtask

    task automatic model_byte(input logic [7:0] b, input bit stop_ok);
        wr_t e;
        if (!stop_ok) begin
            m_ferr = 1;
        end else if (m_len) begin
            m_part.push_back(b);
            if (m_part.size() == 4) begin
                e.addr = 4'(m_addr);
                e.data = {m_part[3], m_part[2], m_part[1], m_part[0]};
                e.cnt  = 16'(m_cnt);
                exp_q.push_back(e);
                m_addr = (m_addr + 1) % 16;
                m_cnt  = m_cnt + 1;
                m_sum  = m_sum + e.data;
                m_part.delete();
            end
        end
    endtask

    // The model is updated before the frame goes out so the expected write is queued ahead of the pulse.
    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        model_byte(b, stop_ok);
        rx_i = 1'b0;
        repeat (10) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (10) @(negedge clk);
        end
        rx_i = stop_ok;
        repeat (10) @(negedge clk);
        rx_i = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        send_byte(w[7:0], 1);
        send_byte(w[15:8], 1);
        send_byte(w[23:16], 1);
        send_byte(w[31:24], 1);
    endtask

    task automatic set_load(input bit v);
        if (v && !m_len) model_clear();
        if (!v) m_part.delete();
        m_len     = v;
        load_en_i = v;
        repeat (6) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        logic [31:0] exp_sum;
`ifdef IM_LOADER_CHECKSUM_EN
        exp_sum = m_sum;
`else
        exp_sum = 32'h0;
`endif
        chk({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({tag, "_word_cnt"}, 32'(word_cnt_o), 32'(m_cnt));
        chk({tag, "_addr"}, 32'(im_addr_o), 32'(m_addr));
        chk({tag, "_frame_err"}, 32'(frame_err_o), 32'(m_ferr));
        chk({tag, "_hold"}, 32'(cpu_hold_o), 32'(m_len));
        chk({tag, "_checksum"}, checksum_o, exp_sum);
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (im_we_o) begin
            chk("we_width", 32'(prev_we), 32'd0);
            if (exp_q.size() == 0) begin
                chk("write_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(im_addr_o), 32'(e.addr));
                chk("wr_data", im_wdata_o, e.data);
                chk("wr_cnt", 32'(word_cnt_o), 32'(e.cnt));
            end
            last_addr = im_addr_o;
            last_data = im_wdata_o;
            n_writes++;
        end
        prev_we = im_we_o;
    end

    initial begin
        int w0;
        n_checks  = 0;
        n_pass    = 0;
        n_writes  = 0;
        prev_we   = 0;
        last_addr = '0;
        last_data = '0;
        m_len     = 0;
        model_clear();
        rx_i      = 1'b1;
        load_en_i = 1'b0;
        rstn      = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_we", 32'(im_we_o), 32'd0);
        chk("rst_addr", 32'(im_addr_o), 32'd0);
        chk("rst_wdata", im_wdata_o, 32'd0);
        chk("rst_cnt", 32'(word_cnt_o), 32'd0);
        chk("rst_ferr", 32'(frame_err_o), 32'd0);
        chk("rst_hold", 32'(cpu_hold_o), 32'd0);
        chk("rst_sum", checksum_o, 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Basic write
        set_load(1);
        send_byte(8'h13, 1);
        send_byte(8'h05, 1);
        send_byte(8'h10, 1);
        send_byte(8'h00, 1);
        repeat (30) @(negedge clk);
        chk("basic_wdata", last_data, 32'h00100513);
        chk("basic_addr", 32'(last_addr), 32'd0);
        chk("basic_cnt", 32'(word_cnt_o), 32'd1);
        chk("basic_hold", 32'(cpu_hold_o), 32'd1);
        check_state("basic");

        // Seventeen back-to-back words wrap the 4-bit address
        set_load(0);
        set_load(1);
        w0 = n_writes;
        for (int i = 0; i < 17; i++) begin
            send_word({8'(i), 8'(i) ^ 8'h5A, ~8'(i), 8'hC3});
        end
        repeat (30) @(negedge clk);
        chk("wrap_writes", 32'(n_writes - w0), 32'd17);
        chk("wrap_last_addr", 32'(last_addr), 32'd0);
        chk("wrap_cnt", 32'(word_cnt_o), 32'd17);
        check_state("wrap");

        // Framing error: byte dropped, flag sticky
        send_byte(8'hAA, 0);
        repeat (20) @(negedge clk);
        chk("ferr_flag", 32'(frame_err_o), 32'd1);
        w0 = n_writes;
        send_word(32'hDEADBEEF);
        repeat (30) @(negedge clk);
        chk("ferr_writes", 32'(n_writes - w0), 32'd1);
        chk("ferr_data", last_data, 32'hDEADBEEF);
        check_state("ferr");

        // Abort partial word and restart
        send_byte(8'h11, 1);
        send_byte(8'h22, 1);
        set_load(0);
        set_load(1);
        chk("abort_ferr_clr", 32'(frame_err_o), 32'd0);
        chk("abort_cnt_clr", 32'(word_cnt_o), 32'd0);
        chk("abort_addr_clr", 32'(im_addr_o), 32'd0);
        send_word(32'h44332211);
        repeat (30) @(negedge clk);
        chk("abort_data", last_data, 32'h44332211);
        chk("abort_addr", 32'(last_addr), 32'd0);
        check_state("abort");

        // Glitch rejection, then a word must still assemble cleanly
        rx_i = 1'b0;
        repeat (3) @(negedge clk);
        rx_i = 1'b1;
        repeat (30) @(negedge clk);
        send_word(32'h0A0B0C0D);
        repeat (30) @(negedge clk);
        chk("glitch_data", last_data, 32'h0A0B0C0D);
        check_state("glitch");

        // Bytes with load mode off are ignored
        set_load(0);
        chk("ignore_hold", 32'(cpu_hold_o), 32'd0);
        w0 = n_writes;
        send_word(32'h12345678);
        repeat (30) @(negedge clk);
        chk("ignore_writes", 32'(n_writes), 32'(w0));
        check_state("ignore");

        // Checksum wraps
        set_load(1);
        send_word(32'hFFFFFFFF);
        send_word(32'h00000002);
        repeat (30) @(negedge clk);
`ifdef IM_LOADER_CHECKSUM_EN
        chk("checksum_lit", checksum_o, 32'h00000001);
`else
        chk("checksum_lit", checksum_o, 32'h00000000);
`endif
        check_state("checksum");

        // Reset in the middle of a frame
        rx_i = 1'b0;
        repeat (25) @(negedge clk);
        rstn = 1'b0;
        rx_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("midrst_we", 32'(im_we_o), 32'd0);
        chk("midrst_cnt", 32'(word_cnt_o), 32'd0);
        model_clear();
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        send_word(32'hCAFEF00D);
        repeat (30) @(negedge clk);
        chk("midrst_data", last_data, 32'hCAFEF00D);
        chk("midrst_addr", 32'(last_addr), 32'd0);
        check_state("midrst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 Parameter CLK_HZ, default 100000000: clk frequency in Hz.
REQ-002 Parameter BAUD, default 115200: UART bit rate; DIV = CLK_HZ/BAUD clocks per bit, integer-truncated.
REQ-003 Parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-004 clk  in  1  system clock; all logic rising-edge.
REQ-005 rstn  in  1  reset, asynchronous, active-low.
REQ-006 rx_i  in  1  UART serial input, 8N1, idle high, asynchronous to clk.
REQ-007 load_en_i  in  1  load-mode switch, asynchronous to clk.
REQ-008 cpu_hold_o  out  1  high holds the CPU in reset while loading.
REQ-009 im_we_o  out  1  one-cycle instruction-memory write strobe.
REQ-010 im_addr_o  out  ADDR_W  word address of the current write.
REQ-011 im_wdata_o  out  32  instruction word to write.
REQ-012 word_cnt_o  out  16  words written since the last load_en rise, saturating at 0xFFFF.
REQ-013 frame_err_o  out  1  sticky flag: a stop bit sampled low.
REQ-014 checksum_o  out  32  running checksum (see Configuration).

Function
REQ-015 rx_i and load_en_i SHALL each pass through a 2-flop synchronizer; all logic uses the synchronized copies.
REQ-016 UART receive FSM states: IDLE, START, DATA, STOP.
- IDLE -> START on a synchronized rx falling edge.
- START: after DIV/2 clocks, rx low -> DATA; rx high -> IDLE (glitch rejected).
- DATA: samples 8 bits at DIV-clock intervals, LSB first.
- STOP: after DIV clocks, rx high -> byte valid; rx low -> byte discarded and frame_err_o set. Either case -> IDLE.
REQ-017 A valid byte SHALL be accepted only while synchronized load_en is 1; otherwise it is dropped. The receive FSM runs regardless of load_en.
REQ-018 Accepted bytes SHALL assemble little-endian: the 1st byte goes to [7:0] and the 4th byte to [31:24]; a 2-bit byte counter tracks position.
REQ-019 On the 4th accepted byte, im_we_o SHALL pulse high for exactly one cycle, in the cycle after the stop-bit sample.
- im_wdata_o holds the assembled word and im_addr_o the current address during the pulse.
- The address increments the cycle after the pulse and wraps from 2^ADDR_W-1 to 0.
- word_cnt_o increments, saturating.
REQ-020 im_addr_o and im_wdata_o SHALL remain stable between pulses.
REQ-021 cpu_hold_o SHALL equal synchronized load_en.
REQ-022 On a synchronized load_en rising edge, the module SHALL clear the address, byte counter, word_cnt_o, frame_err_o and checksum.
REQ-023 On a load_en fall, any partial word SHALL be discarded and the byte counter cleared; no write is issued.
- If the 4th byte completes in the same cycle that load_en falls, that byte is dropped and no write is issued.
REQ-024 The minimum accepted spacing is back-to-back frames with a single stop bit; no byte may be lost at that spacing.

Reset
REQ-025 Reset SHALL set every output to 0, with im_we_o low, and place the FSM in IDLE.
REQ-026 Reset SHALL initialise both synchronizers to idle: rx flops to 1, load_en flops to 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame; reception restarts with the next start bit after release.

Configuration
REQ-028 The macro IM_LOADER_CHECKSUM_EN controls the checksum.
- Defined: checksum_o = 32-bit wrapping sum of all written words, updated in the cycle after each im_we_o pulse and cleared per REQ-022.
- Undefined: checksum_o is tied to 0 and no adder is built.

Structure
REQ-029 A shared package SHALL hold the RX state enum (IDLE/START/DATA/STOP) and the constants DATA_BITS=8 and BYTES_PER_WORD=4.
REQ-030 One sub-module, uart_rx, SHALL contain the synchronizer, baud counter and RX FSM.
- uart_rx outputs: byte_o[7:0], byte_valid_o (one-cycle pulse) and frame_err_o (one-cycle pulse).
- im_loader contains the word assembly, address, hold and checksum logic.

Verification
Bench parameters: CLK_HZ=1000000, BAUD=100000 (DIV=10), ADDR_W=4.
REQ-031 Basic write: load_en=1, send bytes 0x13,0x05,0x10,0x00 -> one im_we_o pulse with addr 0, wdata 0x00100513; word_cnt_o=1; cpu_hold_o=1.
REQ-032 Wrap: send 17 words back-to-back -> the 17th write goes to addr 0 with word_cnt_o=17; no bytes are lost.
REQ-033 Framing error: a frame with 0xAA and stop bit 0 -> byte dropped, frame_err_o=1; the next 4 good bytes produce exactly one write.
REQ-034 Abort and restart: send 2 bytes, drop load_en, then re-raise it and send 4 bytes -> a single write at addr 0 containing only the new bytes; frame_err_o and word_cnt_o are cleared on the rise.
REQ-035 Glitch and ignore: a 3-clock low pulse on rx -> no byte. A full frame with load_en=0 -> no write, and cpu_hold_o=0.
REQ-036 Checksum: with IM_LOADER_CHECKSUM_EN defined, write 0xFFFFFFFF then 0x00000002 -> checksum_o=0x00000001. With the macro undefined -> checksum_o=0.
